// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl: sequencing controller for MIPS I-type immediate instructions.
// Accepts one instruction word in IDLE, decodes the opcode, steps through
// DECODE -> EXEC -> WB (or DECODE -> ERR for unsupported opcodes), and drives
// the extender, ALU and register-file controls. All outputs are registered and
// computed from the state being entered.
module imm_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   input  logic        ovf_in,
   output logic        instr_ready,
   output logic        ext_sign,
   output logic [15:0] imm,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [3:0]  alu_op,
   output logic        alu_src,
   output logic        reg_write,
   output logic        done,
   output logic        illegal,
   output logic        ovf_exc,
   output logic [15:0] retired_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      ERR    = 3'd4
   } state_t;

   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t state_reg;
   logic   legal_reg;    // latched opcode was in the supported map
   logic   is_addi_reg;  // latched opcode is ADDI (the only trapping add)

   // Opcode map: returns {supported, alu_op[3:0], ext_sign}.
   function automatic logic [5:0] decode_op(input logic [5:0] opc);
      logic [5:0] r;
      r = 6'b0;
      case (opc)
         6'b001000: r = {1'b1, 4'b0000, 1'b1}; // ADDI
         6'b001001: r = {1'b1, 4'b0000, 1'b1}; // ADDIU
         6'b001010: r = {1'b1, 4'b0001, 1'b1}; // SLTI
         6'b001011: r = {1'b1, 4'b0010, 1'b1}; // SLTIU
         6'b001100: r = {1'b1, 4'b0011, 1'b0}; // ANDI
         6'b001101: r = {1'b1, 4'b0100, 1'b0}; // ORI
         6'b001110: r = {1'b1, 4'b0101, 1'b0}; // XORI
         6'b001111: r = {1'b1, 4'b0110, 1'b0}; // LUI
         default:   r = 6'b0;
      endcase
      return r;
   endfunction

   logic [5:0] dec;
   assign dec = decode_op(instr[31:26]);

   // Controller FSM with registered outputs; field outputs hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         legal_reg   <= 1'b0;
         is_addi_reg <= 1'b0;
         instr_ready <= 1'b1;
         ext_sign    <= 1'b0;
         imm         <= 16'h0000;
         rs_addr     <= 5'd0;
         rt_addr     <= 5'd0;
         alu_op      <= 4'd0;
         alu_src     <= 1'b0;
         reg_write   <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         ovf_exc     <= 1'b0;
         retired_cnt <= 16'h0000;
      end else begin
         case (state_reg)
            IDLE: begin
               if (instr_valid) begin
                  // Latch the word and present decoded fields from DECODE on.
                  state_reg   <= DECODE;
                  instr_ready <= 1'b0;
                  legal_reg   <= dec[5];
                  is_addi_reg <= (instr[31:26] == OP_ADDI);
                  alu_op      <= dec[4:1];
                  ext_sign    <= dec[0];
                  imm         <= instr[15:0];
                  rs_addr     <= instr[25:21];
                  rt_addr     <= instr[20:16];
               end
            end
            DECODE: begin
               if (legal_reg) begin
                  state_reg <= EXEC;
                  alu_src   <= 1'b1;
               end else begin
                  state_reg <= ERR;
                  illegal   <= 1'b1;
               end
            end
            EXEC: begin
               // ovf_in is captured on this edge and acts only for ADDI.
               state_reg   <= WB;
               done        <= 1'b1;
               ovf_exc     <= is_addi_reg & ovf_in;
               reg_write   <= (rt_addr != 5'd0) && !(is_addi_reg && ovf_in);
               retired_cnt <= retired_cnt + 16'd1;
            end
            WB: begin
               state_reg   <= IDLE;
               instr_ready <= 1'b1;
               alu_src     <= 1'b0;
               done        <= 1'b0;
               ovf_exc     <= 1'b0;
               reg_write   <= 1'b0;
            end
            ERR: begin
               state_reg   <= IDLE;
               instr_ready <= 1'b1;
               illegal     <= 1'b0;
            end
            default: begin
               state_reg   <= IDLE;
               instr_ready <= 1'b1;
               alu_src     <= 1'b0;
               done        <= 1'b0;
               ovf_exc     <= 1'b0;
               reg_write   <= 1'b0;
               illegal     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Testbench for imm_seq_ctrl: directed instruction vectors with hand-computed
// expectations pushed to a scoreboard; a monitor pops and checks every retire
// (done) or illegal pulse.
module tb_imm_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        ovf_in;
   logic        instr_ready;
   logic        ext_sign;
   logic [15:0] imm;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [3:0]  alu_op;
   logic        alu_src;
   logic        reg_write;
   logic        done;
   logic        illegal;
   logic        ovf_exc;
   logic [15:0] retired_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic        ill;
      logic        rw;
      logic        oe;
      logic [3:0]  op;
      logic        es;
      logic [15:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   imm_seq_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .ovf_in      (ovf_in),
      .instr_ready (instr_ready),
      .ext_sign    (ext_sign),
      .imm         (imm),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .alu_op      (alu_op),
      .alu_src     (alu_src),
      .reg_write   (reg_write),
      .done        (done),
      .illegal     (illegal),
      .ovf_exc     (ovf_exc),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one line per retire/illegal transaction, checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("no_strobe_while_ready",
             {31'd0, instr_ready & (reg_write | done | illegal | ovf_exc)}, 32'd0);
         if (done === 1'b1 || illegal === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {30'd0, done, illegal}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("txn: done=%0b illegal=%0b rw=%0b ovf_exc=%0b op=%0h es=%0b imm=%h rs=%0d rt=%0d cnt=%h",
                        done, illegal, reg_write, ovf_exc, alu_op, ext_sign, imm, rs_addr, rt_addr, retired_cnt);
               chk("mon_illegal",   {31'd0, illegal},   {31'd0, e.ill});
               chk("mon_done",      {31'd0, done},      {31'd0, ~e.ill});
               chk("mon_reg_write", {31'd0, reg_write}, {31'd0, e.rw});
               chk("mon_ovf_exc",   {31'd0, ovf_exc},   {31'd0, e.oe});
               chk("mon_cnt",       {16'd0, retired_cnt}, {16'd0, e.cnt});
               if (!e.ill) begin
                  chk("mon_alu_op",   {28'd0, alu_op},   {28'd0, e.op});
                  chk("mon_ext_sign", {31'd0, ext_sign}, {31'd0, e.es});
                  chk("mon_imm",      {16'd0, imm},      {16'd0, e.imm});
                  chk("mon_rs",       {27'd0, rs_addr},  {27'd0, e.rs});
                  chk("mon_rt",       {27'd0, rt_addr},  {27'd0, e.rt});
                  chk("mon_alu_src",  {31'd0, alu_src},  32'd1);
               end
            end
         end
      end
   end

   // Issue one instruction (called at a negedge); returns at the WB-cycle negedge.
   task automatic issue(input logic [31:0] w, input logic ovf, input exp_t e);
      int n;
      instr       = w;
      instr_valid = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      sb.push_back(e);
      #1;
      instr_valid = 1'b0;
      instr       = 32'hDEADBEEF;  // must be ignored while busy
      @(negedge clk);              // DECODE
      chk("dec_ready", {31'd0, instr_ready}, 32'd0);
      chk("dec_alu_src", {31'd0, alu_src}, 32'd0);
      if (!e.ill) begin
         chk("dec_ext_sign", {31'd0, ext_sign}, {31'd0, e.es});
         chk("dec_alu_op",   {28'd0, alu_op},   {28'd0, e.op});
         chk("dec_imm",      {16'd0, imm},      {16'd0, e.imm});
         chk("dec_rt",       {27'd0, rt_addr},  {27'd0, e.rt});
      end
      ovf_in = ovf;
      @(negedge clk);              // EXEC or ERR
      if (e.ill) begin
         chk("err_illegal_at_2", {31'd0, illegal}, 32'd1);
         chk("err_no_write", {31'd0, reg_write}, 32'd0);
      end else begin
         chk("exec_alu_src", {31'd0, alu_src}, 32'd1);
         chk("exec_no_done", {31'd0, done}, 32'd0);
      end
      @(negedge clk);              // WB, or IDLE after ERR
      ovf_in = 1'b0;
      if (e.ill) begin
         chk("err_idle_at_3", {31'd0, instr_ready}, 32'd1);
         chk("err_no_done", {31'd0, done}, 32'd0);
         chk("err_cnt_hold", {16'd0, retired_cnt}, {16'd0, e.cnt});
      end else begin
         chk("wb_done_at_3", {31'd0, done}, 32'd1);
      end
   endtask

   function automatic exp_t mk(input logic ill, input logic rw, input logic oe,
                               input logic [3:0] op, input logic es, input logic [15:0] im,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] cnt);
      exp_t e;
      e.ill = ill; e.rw = rw; e.oe = oe; e.op = op; e.es = es;
      e.imm = im; e.rs = rs; e.rt = rt; e.cnt = cnt;
      return e;
   endfunction

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      ovf_in      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state
      chk("rst_ready",     {31'd0, instr_ready}, 32'd1);
      chk("rst_outputs",   {7'd0, ext_sign, alu_op, alu_src, reg_write, done, illegal, ovf_exc, imm}, 32'd0);
      chk("rst_addr_cnt",  {6'd0, rs_addr, rt_addr, retired_cnt}, 32'd0);
      rst_n = 1'b1;

      //        instr         ovf       ill rw  oe  op       es  imm       rs     rt     cnt
      issue(32'h2001FFFF, 1'b0, mk(1'b0,1'b1,1'b0,4'b0000,1'b1,16'hFFFF,5'd0, 5'd1, 16'd1)); // ADDI
      issue(32'h34028000, 1'b0, mk(1'b0,1'b1,1'b0,4'b0100,1'b0,16'h8000,5'd0, 5'd2, 16'd2)); // ORI
      issue(32'hFC000000, 1'b0, mk(1'b1,1'b0,1'b0,4'b0000,1'b0,16'h0000,5'd0, 5'd0, 16'd2)); // illegal
      issue(32'h20210001, 1'b1, mk(1'b0,1'b0,1'b1,4'b0000,1'b1,16'h0001,5'd1, 5'd1, 16'd3)); // ADDI ovf
      issue(32'h24210001, 1'b1, mk(1'b0,1'b1,1'b0,4'b0000,1'b1,16'h0001,5'd1, 5'd1, 16'd4)); // ADDIU ovf ignored
      issue(32'h24000005, 1'b0, mk(1'b0,1'b0,1'b0,4'b0000,1'b1,16'h0005,5'd0, 5'd0, 16'd5)); // rt=0
      issue(32'h28A4FFF0, 1'b0, mk(1'b0,1'b1,1'b0,4'b0001,1'b1,16'hFFF0,5'd5, 5'd4, 16'd6)); // SLTI
      issue(32'h2C060001, 1'b1, mk(1'b0,1'b1,1'b0,4'b0010,1'b1,16'h0001,5'd0, 5'd6, 16'd7)); // SLTIU
      issue(32'h30E700FF, 1'b0, mk(1'b0,1'b1,1'b0,4'b0011,1'b0,16'h00FF,5'd7, 5'd7, 16'd8)); // ANDI
      issue(32'h3908AAAA, 1'b0, mk(1'b0,1'b1,1'b0,4'b0101,1'b0,16'hAAAA,5'd8, 5'd8, 16'd9)); // XORI
      issue(32'h3C051234, 1'b0, mk(1'b0,1'b1,1'b0,4'b0110,1'b0,16'h1234,5'd0, 5'd5, 16'd10)); // LUI
      issue(32'h00000000, 1'b0, mk(1'b1,1'b0,1'b0,4'b0000,1'b0,16'h0000,5'd0, 5'd0, 16'd10)); // R-type

      // Reset during EXEC aborts the instruction (never pushed to the scoreboard).
      @(negedge clk);
      instr = 32'h20010003; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk);              // DECODE
      @(negedge clk);              // EXEC
      chk("pre_rst_in_exec", {31'd0, alu_src}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready",   {31'd0, instr_ready}, 32'd1);
      chk("mid_rst_outputs", {7'd0, ext_sign, alu_op, alu_src, reg_write, done, illegal, ovf_exc, imm}, 32'd0);
      chk("mid_rst_addr_cnt", {6'd0, rs_addr, rt_addr, retired_cnt}, 32'd0);
      repeat (2) @(negedge clk);

      // Release and hold a back-to-back stream: accepts every 4 cycles from the first edge.
      rst_n = 1'b1;
      instr = 32'h24630007; instr_valid = 1'b1;
      for (int k = 1; k <= 3; k++)
         sb.push_back(mk(1'b0,1'b1,1'b0,4'b0000,1'b1,16'h0007,5'd3,5'd3,16'(k)));
      for (int k = 0; k < 12; k++) begin
         chk("stream_ready", {31'd0, instr_ready}, {31'd0, (k % 4) == 0});
         @(negedge clk);
      end
      instr_valid = 1'b0;

      // Counter wrap: preload 0xFFFF, next retire yields 0x0000.
      force dut.retired_cnt = 16'hFFFF;
      #1 release dut.retired_cnt;
      @(negedge clk);
      issue(32'h24630007, 1'b0, mk(1'b0,1'b1,1'b0,4'b0000,1'b1,16'h0007,5'd3,5'd3,16'h0000));

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
